// File: rtl/chacha_pkg.sv
// chacha_pkg: state type and id-width helper shared by the ChaCha stream arbiter files
package chacha_pkg;
  typedef enum logic {IDLE, BUSY} arb_state_e;
  function automatic int id_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/chacha_stream_arbiter_if.sv
// chacha_stream_arbiter_if: requester-side and datapath-side stream signals of the arbiter
interface chacha_stream_arbiter_if #(
  parameter int NB_REQ = 4,
  parameter int DATA_BUS_W = 32,
  parameter int ID_W = chacha_pkg::id_w(NB_REQ)
);
  logic [NB_REQ-1:0] i_valid, i_ready, i_last;
  logic [NB_REQ*DATA_BUS_W-1:0] i_data;
  logic o_valid, o_ready, o_last, busy;
  logic [DATA_BUS_W-1:0] o_data;
  logic [ID_W-1:0] o_id;
  modport master (output i_valid, i_data, i_last, o_ready, input i_ready, o_valid, o_data, o_last, o_id, busy);
  modport slave (input i_valid, i_data, i_last, o_ready, output i_ready, o_valid, o_data, o_last, o_id, busy);
endinterface

// File: rtl/chacha_rr_pick.sv
// chacha_rr_pick: combinational round-robin winner, first request at or after ptr
module chacha_rr_pick import chacha_pkg::*; #(
  parameter int N = 4,
  localparam int W = id_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] win,
  output logic any
);
  int idx;
  always_comb begin
    win = '0;
    idx = 0;
    // scan from the farthest offset down so the closest request to ptr is written last
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      idx = idx >= N ? idx - N : idx;
      if (req[idx[W-1:0]]) win = idx[W-1:0];
    end
  end
  assign any = |req;
endmodule

// File: rtl/chacha_stream_arbiter.sv
// chacha_stream_arbiter: packet-locked round-robin share of one ChaCha stream input,
// with a registered output stage tagging each beat with its source requester
module chacha_stream_arbiter import chacha_pkg::*; #(
  parameter int NB_REQ = 4,
  parameter int DATA_BUS_W = 32
) (
  input logic aclk,
  input logic aresetn,
  input logic srst,
  chacha_stream_arbiter_if.slave s
);
  localparam int ID_W = id_w(NB_REQ);
  arb_state_e state_q, state_d;
  logic [ID_W-1:0] grant_q, grant_d, ptr_q, ptr_d, o_id_q, o_id_d, win;
  logic [DATA_BUS_W-1:0] o_data_q, o_data_d, beat_data;
  logic o_valid_q, o_valid_d, o_last_q, o_last_d;
  logic any, full, acc, beat_last;
  chacha_rr_pick #(.N(NB_REQ)) u_pick (.req(s.i_valid), .ptr(ptr_q), .win(win), .any(any));
  assign full = o_valid_q & ~s.o_ready;
  assign beat_data = s.i_data[grant_q*DATA_BUS_W +: DATA_BUS_W];
  assign beat_last = s.i_last[grant_q];
  assign acc = state_q == BUSY && !full && s.i_valid[grant_q];
  assign s.i_ready = NB_REQ'(state_q == BUSY && !full) << grant_q;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d = ptr_q;
    if (state_q == IDLE && any) begin
      state_d = BUSY;
      grant_d = win;
    end
    if (acc && beat_last) begin
      state_d = IDLE;
      ptr_d = grant_q == ID_W'(NB_REQ - 1) ? '0 : grant_q + 1'b1;
    end
    o_valid_d = full ? o_valid_q : acc;
    o_data_d = !full && acc ? beat_data : o_data_q;
    o_last_d = !full && acc ? beat_last : o_last_q;
    o_id_d = !full && acc ? grant_q : o_id_q;
    // synchronous reset drops the packet in flight and any held output beat
    if (srst) begin
      state_d = IDLE;
      grant_d = '0;
      ptr_d = '0;
      o_valid_d = 1'b0;
      o_data_d = '0;
      o_last_d = 1'b0;
      o_id_d = '0;
    end
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q <= '0;
      o_valid_q <= 1'b0;
      o_data_q <= '0;
      o_last_q <= 1'b0;
      o_id_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q <= ptr_d;
      o_valid_q <= o_valid_d;
      o_data_q <= o_data_d;
      o_last_q <= o_last_d;
      o_id_q <= o_id_d;
    end
  assign s.o_valid = o_valid_q;
  assign s.o_data = o_data_q;
  assign s.o_last = o_last_q;
  assign s.o_id = o_id_q;
  assign s.busy = state_q == BUSY;
endmodule

// File: tb/tb_chacha_stream_arbiter.sv
// tb_chacha_stream_arbiter: directed scenarios plus a randomized packet-order scoreboard
module tb_chacha_stream_arbiter;
  import chacha_pkg::*;
  localparam int N = 4, W = 32;
  logic aclk = 1'b0, aresetn = 1'b0, srst = 1'b0;
  int n = 0, errs = 0;
  logic [W:0] rq[N][$];
  logic [W:0] cq[N][$];
  logic [63:0] exq[$];
  logic [63:0] e, held;
  logic [W:0] b;
  logic [N-1:0] started;
  logic hold_v;
  int cnt[N];
  int p, found, j;
  always #5 aclk = ~aclk;
  chacha_stream_arbiter_if #(.NB_REQ(N), .DATA_BUS_W(W)) bus ();
  chacha_stream_arbiter #(.NB_REQ(N), .DATA_BUS_W(W)) dut (.aclk(aclk), .aresetn(aresetn), .srst(srst), .s(bus.slave));
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask
  task automatic smp();
    @(negedge aclk);
  endtask
  task automatic set_req(int r, logic v, logic [W-1:0] d, logic l);
    bus.i_valid[r] = v;
    bus.i_data[r*W +: W] = d;
    bus.i_last[r] = l;
  endtask
  task automatic chk_out(string tag, logic [W-1:0] d, int id, logic l);
    chk({tag, "_valid"}, 64'(bus.o_valid), 64'(1));
    chk({tag, "_data"}, 64'(bus.o_data), 64'(d));
    chk({tag, "_id"}, 64'(bus.o_id), 64'(id));
    chk({tag, "_last"}, 64'(bus.o_last), 64'(l));
  endtask
  task automatic chk_rst(string tag);
    chk({tag, "_ovalid"}, 64'(bus.o_valid), 64'(0));
    chk({tag, "_odata"}, 64'(bus.o_data), 64'(0));
    chk({tag, "_olast"}, 64'(bus.o_last), 64'(0));
    chk({tag, "_oid"}, 64'(bus.o_id), 64'(0));
    chk({tag, "_busy"}, 64'(bus.busy), 64'(0));
    chk({tag, "_iready"}, 64'(bus.i_ready), 64'(0));
  endtask
  task automatic chk_rdy(string tag, logic [N-1:0] exp);
    chk(tag, 64'(bus.i_ready), 64'(exp));
  endtask
  initial begin
    bus.i_valid = '0;
    bus.i_data = '0;
    bus.i_last = '0;
    bus.o_ready = 1'b1;
    repeat (2) tick();
    chk_rst("reset");
    aresetn = 1'b1;
    // single requester: req 2 sends A0,A1,A2
    tick(); set_req(2, 1, 32'hA0, 0); smp();
    chk_rdy("single_c0_ready", 4'b0000);
    tick(); smp();
    chk_rdy("single_c1_ready", 4'b0100);
    chk("single_c1_busy", 64'(bus.busy), 64'(1));
    tick(); set_req(2, 1, 32'hA1, 0); smp();
    chk_out("single_c2", 32'hA0, 2, 0);
    tick(); set_req(2, 1, 32'hA2, 1); smp();
    chk_out("single_c3", 32'hA1, 2, 0);
    tick(); set_req(2, 0, 0, 0); smp();
    chk_out("single_c4", 32'hA2, 2, 1);
    chk("single_c4_busy", 64'(bus.busy), 64'(0));
    // wrap: ptr is 3, req 0 and req 3 both request
    tick(); set_req(0, 1, 32'hB0, 1); set_req(3, 1, 32'hC0, 1); smp();
    tick(); smp();
    chk_rdy("wrap_first_ready", 4'b1000);
    tick(); set_req(3, 0, 0, 0); smp();
    chk_out("wrap_first", 32'hC0, 3, 1);
    chk_rdy("wrap_idle_ready", 4'b0000);
    tick(); smp();
    chk_rdy("wrap_second_ready", 4'b0001);
    chk("wrap_bubble", 64'(bus.o_valid), 64'(0));
    tick(); set_req(0, 0, 0, 0); smp();
    chk_out("wrap_second", 32'hB0, 0, 1);
    // lock: req 1 holds the grant through a 5-cycle gap while req 0 waits
    tick(); set_req(1, 1, 32'hD0, 0); set_req(0, 1, 32'hE0, 1); smp();
    tick(); smp();
    chk_rdy("lock_grant", 4'b0010);
    tick(); set_req(1, 0, 0, 0); smp();
    chk_rdy("lock_gap", 4'b0010);
    for (int i = 0; i < 4; i++) begin
      tick(); smp();
      chk_rdy("lock_gap", 4'b0010);
    end
    tick(); set_req(1, 1, 32'hD1, 1); smp();
    chk_rdy("lock_last", 4'b0010);
    tick(); set_req(1, 0, 0, 0); smp();
    chk_out("lock_out", 32'hD1, 1, 1);
    chk_rdy("lock_idle", 4'b0000);
    tick(); smp();
    chk_rdy("lock_req0", 4'b0001);
    tick(); set_req(0, 0, 0, 0); smp();
    chk_out("lock_req0_out", 32'hE0, 0, 1);
    // backpressure: o_ready low 4 cycles mid-packet
    tick(); set_req(2, 1, 32'hF0, 0); smp();
    tick(); smp();
    chk_rdy("bp_grant", 4'b0100);
    tick(); set_req(2, 1, 32'hF1, 0); smp();
    chk_out("bp_f0", 32'hF0, 2, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) set_req(2, 1, 32'hF2, 0);
      bus.o_ready = 1'b0;
      smp();
      chk_out("bp_hold", 32'hF1, 2, 0);
      chk_rdy("bp_full_ready", 4'b0000);
    end
    tick(); bus.o_ready = 1'b1; smp();
    chk_out("bp_release", 32'hF1, 2, 0);
    chk_rdy("bp_resume_ready", 4'b0100);
    tick(); set_req(2, 1, 32'hF3, 1); smp();
    chk_out("bp_f2", 32'hF2, 2, 0);
    tick(); set_req(2, 0, 0, 0); smp();
    chk_out("bp_f3", 32'hF3, 2, 1);
    tick(); smp();
    chk("bp_done", 64'(bus.o_valid), 64'(0));
    // synchronous reset during beat 2 of 4
    tick(); set_req(3, 1, 32'h60, 0); smp();
    tick(); smp();
    tick(); set_req(3, 1, 32'h61, 0); srst = 1'b1; smp();
    chk_out("srst_before", 32'h60, 3, 0);
    tick(); srst = 1'b0; set_req(3, 0, 0, 0); smp();
    chk_rst("srst_after");
    tick(); set_req(1, 1, 32'h70, 1); smp();
    tick(); smp();
    chk_rdy("srst_new_grant", 4'b0010);
    tick(); set_req(1, 0, 0, 0); smp();
    chk_out("srst_new_out", 32'h70, 1, 1);
    // asynchronous reset mid-packet, between clock edges
    tick(); set_req(2, 1, 32'h80, 0); smp();
    tick(); smp();
    aresetn = 1'b0;
    #1;
    chk_rst("areset_async");
    set_req(2, 0, 0, 0);
    #1;
    aresetn = 1'b1;
    // fairness: all requesters stream 1-beat packets
    for (int r = 0; r < N; r++) cnt[r] = 0;
    tick();
    for (int r = 0; r < N; r++) set_req(r, 1, 32'(32'h100 * r), 1);
    smp();
    for (int c = 1; c < 18; c++) begin
      tick();
      for (int r = 0; r < N; r++) set_req(r, 1, 32'(32'h100 * r + cnt[r]), 1);
      smp();
      for (int r = 0; r < N; r++) if (bus.i_ready[r]) cnt[r]++;
      if (c >= 2 && c % 2 == 0) begin
        j = c / 2 - 1;
        chk_out("fair", 32'(32'h100 * (j % N) + j / N), j % N, 1);
      end else if (c >= 2) chk("fair_bubble", 64'(bus.o_valid), 64'(0));
    end
    bus.i_valid = '0;
    // randomized packets against a packet-level round-robin order model
    tick(); srst = 1'b1;
    tick(); srst = 1'b0;
    for (int r = 0; r < N; r++) begin
      rq[r].delete();
      for (int k = $urandom_range(2, 4); k > 0; k--) begin
        int len;
        len = $urandom_range(1, 4);
        for (int i = 0; i < len; i++) rq[r].push_back({i == len - 1, 32'($urandom)});
      end
      cq[r] = rq[r];
    end
    p = 0;
    exq.delete();
    forever begin
      found = -1;
      for (int k = 0; k < N; k++) if (found < 0 && cq[(p + k) % N].size() > 0) found = (p + k) % N;
      if (found < 0) break;
      do begin
        b = cq[found].pop_front();
        exq.push_back(64'({2'(found), b}));
      end while (!b[W]);
      p = (found + 1) % N;
    end
    started = '0;
    hold_v = 1'b0;
    held = '0;
    for (int c = 0; c < 3000 && exq.size() > 0; c++) begin
      tick();
      for (int r = 0; r < N; r++)
        if (rq[r].size() > 0) set_req(r, !started[r] || $urandom_range(0, 3) != 0, rq[r][0][W-1:0], rq[r][0][W]);
        else set_req(r, 0, 0, 0);
      bus.o_ready = $urandom_range(0, 9) < 7;
      smp();
      if (hold_v) chk("rand_hold", 64'({bus.o_valid, bus.o_id, bus.o_last, bus.o_data}), held);
      chk("rand_onehot", 64'($onehot0(bus.i_ready)), 64'(1));
      for (int r = 0; r < N; r++)
        if (bus.i_ready[r] && bus.i_valid[r]) begin
          b = rq[r].pop_front();
          started[r] = !b[W];
        end
      if (bus.o_valid && bus.o_ready) begin
        e = exq.pop_front();
        chk("rand_beat", 64'({bus.o_id, bus.o_last, bus.o_data}), e);
      end
      hold_v = bus.o_valid && !bus.o_ready;
      held = 64'({bus.o_valid, bus.o_id, bus.o_last, bus.o_data});
    end
    chk("rand_drain", 64'(exq.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
